// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared branch-predictor definitions. Holds the PHT alias
//                width shared with bp_gshare and the resolve-queue entry type.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int BP_ALIAS_W  = 6;
    localparam int BP_RQ_DEPTH = 8;

    // One in-flight branch: PHT alias in the upper bits, predicted direction in bit 0
    typedef struct packed {
        logic [BP_ALIAS_W-1:0] bp_alias;
        logic                  pred;
    } bp_rq_entry_t;

    function automatic bp_rq_entry_t bp_rq_pack(input logic [BP_ALIAS_W-1:0] a,
                                                input logic                  p);
        bp_rq_entry_t e;
        e.bp_alias = a;
        e.pred     = p;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_rq_storage.sv
`default_nettype none
// ============================================================================
//  Module      : bp_rq_storage (+ regn, decodern)
//  Description : DEPTH x W register array for the resolve queue with one
//                decoded write port and one combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================

// Enabled W-bit register; contents need no reset
module regn #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // Capture data when enabled
    always_ff @(posedge clk) begin
        if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// Binary-to-one-hot decoder gated by an enable
module decodern #(
    parameter int W = 3,
    parameter int N = 8
) (
    input  logic         i_en,
    input  logic [W-1:0] i_sel,
    output logic [N-1:0] o_onehot
);
    // Assert exactly one line when enabled, none otherwise
    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_sel] = 1'b1;
    end
endmodule

module bp_rq_storage #(
    parameter int DEPTH = 8,
    parameter int W     = 7
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_ptr,
    input  logic [W-1:0]             i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
    output logic [W-1:0]             o_rd_data
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] w_we;
    logic [W-1:0]     w_q [DEPTH];

    decodern #(.W(c_PTR_W), .N(DEPTH)) u_dec (
        .i_en     (i_wr_en),
        .i_sel    (i_wr_ptr),
        .o_onehot (w_we)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        regn #(.W(W)) u_reg (
            .clk  (clk),
            .i_en (w_we[i]),
            .i_d  (i_wr_data),
            .o_q  (w_q[i])
        );
    end

    assign o_rd_data = w_q[i_rd_ptr];
endmodule
`default_nettype wire

// File: rtl/bp_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module      : bp_resolve_queue
//  Description : In-order queue of predicted branches between fetch and
//                resolution. Pairs the oldest entry with its actual outcome,
//                drives the predictor update port and flags mispredicts.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH   = BP_RQ_DEPTH,
    parameter int ALIAS_W = BP_ALIAS_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    input  logic [ALIAS_W-1:0]     push_alias,
    input  logic                   push_pred,
    output logic                   push_ready,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic                   flush,
    output logic                   prev_is_BR,
    output logic [ALIAS_W-1:0]     prev_BR_alias,
    output logic                   prev_BR_result,
    output logic                   mispredict,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   underflow
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_prev_is_br;
    logic [ALIAS_W-1:0] r_prev_alias;
    logic               r_prev_result;
    logic               r_mispredict;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic [ALIAS_W:0]   w_head;
    logic               w_res_do;
    logic               w_mis_now;
    logic               w_push_do;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A mispredicting resolve kills the same-cycle push along with all younger entries
    assign w_res_do  = res_valid && !w_empty;
    assign w_mis_now = w_res_do && (res_taken != w_head[0]);
    assign w_push_do = push_valid && !w_full && !flush && !w_mis_now;

    bp_rq_storage #(.DEPTH(DEPTH), .W(ALIAS_W + 1)) u_storage (
        .clk       (clk),
        .i_wr_en   (w_push_do),
        .i_wr_ptr  (r_tail),
        .i_wr_data ({push_alias, push_pred}),
        .i_rd_ptr  (r_head),
        .o_rd_data (w_head)
    );

    // Pointer/count bookkeeping; flush or mispredict collapses the queue onto the tail
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush || w_mis_now) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push_do) r_tail <= r_tail + c_PTR_W'(1);
            if (w_res_do)  r_head <= r_head + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(w_push_do) - c_CNT_W'(w_res_do);
        end
    end

    // Registered predictor-update port, mispredict pulse and sticky underflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_is_br  <= 1'b0;
            r_prev_alias  <= '0;
            r_prev_result <= 1'b0;
            r_mispredict  <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_prev_is_br <= w_res_do;
            r_mispredict <= w_mis_now;
            if (w_res_do) begin
                r_prev_alias  <= w_head[ALIAS_W:1];
                r_prev_result <= res_taken;
            end
            if (res_valid && w_empty) r_underflow <= 1'b1;
        end
    end

    assign push_ready     = !w_full;
    assign full           = w_full;
    assign empty          = w_empty;
    assign count          = r_count;
    assign prev_is_BR     = r_prev_is_br;
    assign prev_BR_alias  = r_prev_alias;
    assign prev_BR_result = r_prev_result;
    assign mispredict     = r_mispredict;
    assign underflow      = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_bp_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_resolve_queue
//  Description : Directed, scoreboarded bench for bp_resolve_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_resolve_queue;
    import bp_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push_valid = 1'b0;
    logic [5:0] push_alias = '0;
    logic       push_pred = 1'b0;
    logic       push_ready;
    logic       res_valid = 1'b0;
    logic       res_taken = 1'b0;
    logic       flush = 1'b0;
    logic       prev_is_BR;
    logic [5:0] prev_BR_alias;
    logic       prev_BR_result;
    logic       mispredict;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       underflow;

    typedef struct {
        logic [5:0] a;
        logic       r;
        logic       m;
    } exp_t;

    exp_t         sb[$];
    bp_rq_entry_t mq[$];
    logic         exp_uf = 1'b0;
    int           total = 0;
    int           bad = 0;

    bp_resolve_queue #(.DEPTH(8), .ALIAS_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .push_valid     (push_valid),
        .push_alias     (push_alias),
        .push_pred      (push_pred),
        .push_ready     (push_ready),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .flush          (flush),
        .prev_is_BR     (prev_is_BR),
        .prev_BR_alias  (prev_BR_alias),
        .prev_BR_result (prev_BR_result),
        .mispredict     (mispredict),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    // Monitor: every update pulse is matched against the oldest expected resolve
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_is_BR) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL pulse_unexpected: got alias=%h result=%b mis=%b, required no pulse",
                             prev_BR_alias, prev_BR_result, mispredict);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (prev_BR_alias !== e.a || prev_BR_result !== e.r || mispredict !== e.m) begin
                        bad++;
                        $display("FAIL update: got alias=%h result=%b mis=%b, required alias=%h result=%b mis=%b",
                                 prev_BR_alias, prev_BR_result, mispredict, e.a, e.r, e.m);
                    end
                end
            end else if (mispredict !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL mis_without_update: got mispredict=%b, required 0", mispredict);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // One clock with the given inputs; model records the expected pulse and queue state
    task automatic cyc(input logic pv, input logic [5:0] pa, input logic pp,
                       input logic rv, input logic rt, input logic fl, input logic rs);
        logic res_do, mis, push_do;
        push_valid = pv; push_alias = pa; push_pred = pp;
        res_valid = rv; res_taken = rt; flush = fl; reset = rs;
        if (rs) begin
            mq.delete();
            sb.delete();
            exp_uf = 1'b0;
        end else begin
            res_do  = rv && (mq.size() != 0);
            mis     = res_do && (rt != mq[0].pred);
            push_do = pv && (mq.size() != 8) && !fl && !mis;
            if (rv && mq.size() == 0) exp_uf = 1'b1;
            if (res_do) begin
                sb.push_back('{mq[0].bp_alias, rt, mis});
                void'(mq.pop_front());
            end
            if (fl || mis) mq.delete();
            else if (push_do) mq.push_back(bp_rq_pack(pa, pp));
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0; res_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    task automatic push(input logic [5:0] a, input logic p);
        cyc(1'b1, a, p, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic t);
        cyc(1'b0, 6'h00, 1'b0, 1'b1, t, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && mq.size() != 0; k++) resolve(mq[0].pred);
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},   int'(count), 0);
        chk({tag, "_empty"},   int'(empty), 1);
        chk({tag, "_full"},    int'(full), 0);
        chk({tag, "_ready"},   int'(push_ready), 1);
        chk({tag, "_isbr"},    int'(prev_is_BR), 0);
        chk({tag, "_alias"},   int'(prev_BR_alias), 0);
        chk({tag, "_result"},  int'(prev_BR_result), 0);
        chk({tag, "_mis"},     int'(mispredict), 0);
        chk({tag, "_uflow"},   int'(underflow), 0);
    endtask

    initial begin
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_reset_state("rst");

        // Basic in-order resolve, all predictions correct
        push(6'h05, 1'b1);
        push(6'h2A, 1'b0);
        push(6'h3F, 1'b1);
        chk("basic_count", int'(count), 3);
        chk("basic_empty", int'(empty), 0);
        resolve(1'b1);
        resolve(1'b0);
        resolve(1'b1);
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("basic_empty_end", int'(empty), 1);

        // Fill to full; push while full is dropped even with a same-cycle pop
        for (int i = 0; i < 8; i++) push(6'(8'h18 + i), i[0]);
        chk("full_flag", int'(full), 1);
        chk("full_ready", int'(push_ready), 0);
        chk("full_count", int'(count), 8);
        cyc(1'b1, 6'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_drop_count", int'(count), 7);
        drain();
        chk("full_drained", int'(empty), 1);

        // Mispredict kills younger entries and the same-cycle push
        push(6'h10, 1'b1);
        push(6'h11, 1'b0);
        push(6'h12, 1'b1);
        push(6'h13, 1'b0);
        cyc(1'b1, 6'h14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mis_count", int'(count), 0);
        chk("mis_empty", int'(empty), 1);
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mis_pulse_gone", int'(mispredict), 0);
        chk("mis_alias_hold", int'(prev_BR_alias), 6'h10);

        // Flush with a correct resolve still updates for the head
        push(6'h20, 1'b1);
        push(6'h21, 1'b0);
        cyc(1'b1, 6'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_count", int'(count), 0);
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Resolve on empty: underflow, no pulse, push still accepted
        cyc(1'b1, 6'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("uflow_flag", int'(underflow), int'(exp_uf));
        chk("uflow_count", int'(count), 1);
        drain();

        // Pointer wrap with 20 push/resolve pairs, then reset mid-stream
        push(6'h2F, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 6'((8'h30 + i) & 8'h3F), i[1], 1'b1, mq[0].pred, 1'b0, 1'b0);
            chk("wrap_count", int'(count), 1);
        end
        cyc(1'b1, 6'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_reset_state("midrst");
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: got %0d outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
- In-order queue sitting between fetch/predict (bp_gshare) and branch resolution (execute/writeback).
- Records each fetched branch's PHT alias and predicted direction. At resolution, pairs the head entry with the actual outcome.
- Drives the predictor update port (prev_is_BR, prev_BR_alias, prev_BR_result) and raises a mispredict pulse when the prediction was wrong.

Parameters:
- DEPTH, 8, number of in-flight branches; power of 2, minimum 2.
- ALIAS_W, 6, PHT alias width; must equal the gshare alias width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  fetch has a predicted branch this cycle.
- push_alias  in  ALIAS_W  BP_alias produced by the predictor for that branch.
- push_pred  in  1  predicted direction (1 = taken).
- push_ready  out  1  = !full; combinational from current state only.
- res_valid  in  1  oldest in-flight branch resolved this cycle.
- res_taken  in  1  actual direction.
- flush  in  1  external pipeline flush (exception/redirect); discards all entries.
- prev_is_BR  out  1  one-cycle pulse: predictor update valid.
- prev_BR_alias  out  ALIAS_W  alias of the resolved branch.
- prev_BR_result  out  1  actual direction of the resolved branch.
- mispredict  out  1  one-cycle pulse: resolved direction != stored prediction.
- count  out  log2(DEPTH)+1  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- underflow  out  1  sticky: res_valid seen while empty; cleared only by reset.

Behaviour:
- Reset (sync, high): head = tail = 0, count = 0, empty = 1, full = 0, push_ready = 1, prev_is_BR = 0, prev_BR_alias = 0, prev_BR_result = 0, mispredict = 0, underflow = 0. Storage contents are don't-care.
- Push: accepted iff push_valid && !full && !flush && !mis_now. The entry {alias, pred} is written at tail, and tail increments modulo DEPTH.
- Push-ready rule: push_ready does not account for a same-cycle pop. A push while full is dropped even if res_valid pops that cycle.
- Resolve: processed iff res_valid && !empty.
  - Head entry is read.
  - On the next edge: prev_is_BR = 1, prev_BR_alias = head.alias, prev_BR_result = res_taken, mispredict = (res_taken != head.pred).
  - Head increments.
  - Latency: resolve cycle N gives outputs valid during cycle N+1 only. All outputs are registered.
- mis_now = resolve processed && res_taken != head.pred.
  - All younger entries are discarded at the same edge: head = tail, count = 0.
  - A same-cycle push is dropped.
- flush: at the edge, the queue empties (head = tail, count = 0) and a same-cycle push is dropped.
  - A same-cycle valid resolve is still processed first: update and mispredict pulses are emitted.
- res_valid while empty: no update and no pulse; underflow is set to 1. A same-cycle push is still accepted; there is no bypass.
- Simultaneous push and resolve, not full and not empty, no mispredict: both occur and count is unchanged.
- Pointers wrap modulo DEPTH. count is tracked explicitly and is never derived from the pointers alone.
- Idle cycles: prev_is_BR = 0 and mispredict = 0; prev_BR_alias and prev_BR_result hold their last values.
- Reset mid-operation overrides everything; no pulse is emitted on the reset edge.

Decomposition:
- Shared bp package: BP_ALIAS_W = 6 (also used by bp_gshare), plus the entry typedef {alias[ALIAS_W-1:0], pred}.
- One sub-module: bp_rq_storage.
  - DEPTH x (ALIAS_W+1) register array.
  - One write port (wr_en, wr_ptr, wr_data) and one combinational read port (rd_ptr, rd_data).
  - Built from regn instances with decodern write-enable.
- Pointer, count and control logic live in bp_resolve_queue.

Test Plan:
- Reset, then push 3 entries (alias 0x05/pred 1, 0x2A/0, 0x3F/1). Then count = 3 and empty = 0. Resolve taken, not-taken, taken: three consecutive prev_is_BR pulses one cycle later with aliases 0x05, 0x2A, 0x3F, mispredict never asserted, empty = 1 at end.
- Fill 8 entries: full = 1, push_ready = 0. A 9th push together with a resolve: push dropped, count = 7 after the edge.
- Push 4 entries, resolve head (pred 1) with res_taken = 0: next cycle mispredict = 1, prev_BR_result = 0, prev_BR_alias = head alias, count = 0. A push in the mispredict cycle is dropped.
- Push 2 entries, assert flush together with a correct resolve: update pulse emitted for the head, count = 0, no mispredict.
- On an empty queue, res_valid with push_valid (alias 0x11): underflow = 1, no prev_is_BR pulse, count = 1.
- Run 20 push/resolve pairs to wrap the pointers: aliases come out in push order, and assert reset mid-stream: all outputs at reset values next cycle, no pulse.
